// File: rtl/fifo_rd_stream_if.sv
// Read-side stream bundle: FIFO read port on one side, valid/ready stream on the other.
// The master modport is the adapter's view; the slave modport is the environment's view.
interface fifo_rd_stream_if #(
    parameter int DW = 8,
    parameter int CW = 3
);
    logic          r_empty;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] buf_cnt;

    modport master (
        input  r_empty, r_data, flush, m_ready,
        output r_en, m_valid, m_data, buf_cnt
    );

    modport slave (
        output r_empty, r_data, flush, m_ready,
        input  r_en, m_valid, m_data, buf_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// FWFT adapter: turns the FIFO's 1-cycle-latency r_en/r_empty port into a valid/ready stream.
// A small prefetch buffer with credit-based issue keeps m_ready out of the r_en path.
module fifo_rd_stream #(
    parameter int DW        = 8,
    parameter int BUF_DEPTH = 3,
    parameter int CW        = 3
) (
    input  logic            r_clk,
    input  logic            r_rst,
    fifo_rd_stream_if.master bus
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DW-1:0] mem [BUF_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] occ;
    logic          inflight;
    logic          discard;

    logic          rd_issue;
    logic          capture;
    logic          pop;
    logic [CW:0]   credit;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // occ + inflight counts every word already claimed from the FIFO
    assign credit   = {1'b0, occ} + (CW+1)'(inflight);
    assign rd_issue = !r_rst && !bus.flush && !bus.r_empty
                      && (credit < (CW+1)'(BUF_DEPTH));
    assign capture  = inflight && !discard;
    assign pop      = bus.m_valid && bus.m_ready;

    assign bus.r_en    = rd_issue;
    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = bus.m_valid ? mem[head] : '0;
    assign bus.buf_cnt = occ;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else if (bus.flush) begin
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= rd_issue;
            discard  <= inflight;
        end else begin
            inflight <= rd_issue;
            discard  <= 1'b0;
            occ      <= occ + CW'(capture) - CW'(pop);
            if (capture)
                tail <= wrap_inc(tail);
            if (pop)
                head <= wrap_inc(head);
        end
    end

    // storage is not reset; m_data is masked until a word is valid
    always_ff @(posedge r_clk) begin
        if (capture)
            mem[tail] <= bus.r_data;
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a queue-based model of words in flight.
// The model tracks words claimed from the FIFO but not yet delivered.
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int BD = 3;
    localparam int CW = 3;

    logic r_clk;
    logic r_rst;

    fifo_rd_stream_if #(.DW(DW), .CW(CW)) bus ();

    fifo_rd_stream #(.DW(DW), .BUF_DEPTH(BD), .CW(CW)) dut (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .bus   (bus.master)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] src [$];
    logic [DW-1:0] exp_q [$];
    bit  infl;
    int  n_ren;
    int  n_del;
    int  max_cnt;
    bit  obs_valid;
    bit  grab;
    logic [DW-1:0] first_word;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc(input bit rdy, input bit fl, input bit rst,
                       input bit pess);
        bit ren_m;
        bit val_m;
        int occ_m;
        logic [DW-1:0] w;
        bus.m_ready = rdy;
        bus.flush   = fl;
        r_rst       = rst;
        bus.r_empty = (src.size() == 0) || pess;
        @(negedge r_clk);
        occ_m = exp_q.size() - int'(infl);
        val_m = (occ_m != 0);
        ren_m = !rst && !fl && !bus.r_empty && (exp_q.size() < BD);
        chk("r_en", 32'(bus.r_en), 32'(ren_m));
        chk("m_valid", 32'(bus.m_valid), 32'(val_m));
        chk("buf_cnt", 32'(bus.buf_cnt), 32'(occ_m));
        if (val_m)
            chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
        if (bus.r_en)
            n_ren++;
        if (int'(bus.buf_cnt) > max_cnt)
            max_cnt = int'(bus.buf_cnt);
        obs_valid = bus.m_valid;
        w = DW'($urandom);
        @(posedge r_clk);
        #1;
        if (rst || fl) begin
            exp_q.delete();
            infl = 1'b0;
        end else begin
            if (val_m && rdy) begin
                if (grab) begin
                    first_word = exp_q[0];
                    grab = 1'b0;
                end
                void'(exp_q.pop_front());
                n_del++;
            end
            infl = ren_m;
            if (ren_m) begin
                w = src.pop_front();
                exp_q.push_back(w);
            end
        end
        bus.r_data = w;
    endtask

    initial begin
        int d0;
        int r0;
        int first_v;
        r_rst       = 1'b1;
        bus.r_empty = 1'b1;
        bus.r_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        infl = 1'b0;
        grab = 1'b0;
        n_ren = 0;
        n_del = 0;
        repeat (2) @(posedge r_clk);
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_buf_cnt", 32'(bus.buf_cnt), 32'd0);
        chk("rst_r_en", 32'(bus.r_en), 32'd0);

        // first-word latency and full rate
        src = '{8'h11, 8'h22, 8'h33};
        max_cnt = 0;
        first_v = -1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (obs_valid && first_v < 0)
                first_v = i;
        end
        chk("first_valid_cycle", 32'(first_v), 32'd2);
        chk("stream_max_cnt", 32'(max_cnt), 32'd1);

        // stalled consumer
        for (int i = 0; i < 8; i++)
            src.push_back(8'h40 + 8'(i));
        r0 = n_ren;
        d0 = n_del;
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_pulses", 32'(n_ren - r0), 32'd3);
        chk("stall_buf_cnt", 32'(bus.buf_cnt), 32'd3);
        chk("stall_r_en", 32'(bus.r_en), 32'd0);
        repeat (14) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_delivered", 32'(n_del - d0), 32'd8);

        // empty boundary
        src = '{8'hA0, 8'hA1};
        d0 = n_del;
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("empty_delivered", 32'(n_del - d0), 32'd2);
        chk("empty_m_valid", 32'(bus.m_valid), 32'd0);

        // flush with a read in flight
        src = '{8'h50, 8'h51, 8'h52, 8'h5C};
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_cnt", 32'(bus.buf_cnt), 32'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        grab = 1'b1;
        first_word = '0;
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_first_word", 32'(first_word), 32'h5C);

        // wrap-around with random ready
        src.delete();
        for (int i = 0; i < 20; i++)
            src.push_back(8'(i));
        d0 = n_del;
        max_cnt = 0;
        for (int i = 0; i < 300 && (n_del - d0) < 20; i++)
            cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        chk("wrap_delivered", 32'(n_del - d0), 32'd20);
        chk("wrap_max_cnt_le3", 32'(max_cnt <= BD), 32'd1);

        // reset mid-stream
        src = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(bus.buf_cnt), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_buf_cnt", 32'(bus.buf_cnt), 32'd0);
        chk("mid_rst_m_data", 32'(bus.m_data), 32'd0);
        chk("mid_rst_r_en", 32'(bus.r_en), 32'd0);
        r_rst = 1'b0;
        #1;
        chk("post_rst_r_en", 32'(bus.r_en), 32'd1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // random stress: ready, pessimistic empty, flush, refill
        for (int i = 0; i < 400; i++) begin
            if (src.size() < 4 && $urandom_range(0, 3) == 0)
                src.push_back(DW'($urandom));
            cyc(1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 4) == 0));
        end
        chk("stress_max_cnt_le3", 32'(max_cnt <= BD), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
